// File: rtl/irq_msgq.sv
// Interrupt message queue: captures controller messages into a FWFT FIFO, acks them, and serves the CPU side.
// Optional macro IRQ_MSGQ_DROP_EN: drop (with ack and sticky overflow) instead of backpressure when full.
module irq_msgq #(
  parameter int DEPTH  = 8,
  parameter int LINE_W = 8,
  parameter int CPU_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       notify,
  input  logic [LINE_W-1:0]          lineno,
  input  logic [CPU_W-1:0]           processor_id,
  output logic                       irqack,
  output logic                       msg_valid,
  output logic [LINE_W-1:0]          msg_lineno,
  output logic [CPU_W-1:0]           msg_cpu,
  input  logic                       msg_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [1:0]                 o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = LINE_W + CPU_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Handshake: the head entry leaves on a posedge where msg_valid && msg_ready.
  // msg_valid never depends on msg_ready, and the head stays stable until popped.

  state_t          r_state;
  state_t          w_next;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [EW-1:0]   w_head;
`ifdef IRQ_MSGQ_DROP_EN
  logic            w_drop;
  logic            r_ovf;
`endif

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && msg_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A full FIFO still accepts a push when a pop frees the slot on the same edge.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
`ifdef IRQ_MSGQ_DROP_EN
    w_drop = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!notify) begin
          if (!w_full || w_pop) begin
            w_push = 1'b1;
            w_next = ACK;
          end
`ifdef IRQ_MSGQ_DROP_EN
          else begin
            w_drop = 1'b1;
            w_next = ACK;
          end
`endif
        end
      end
      ACK:      w_next = WAIT_REL;
      WAIT_REL: if (notify) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {lineno, processor_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

`ifdef IRQ_MSGQ_DROP_EN
  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end
  assign overflow = r_ovf;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_ovf;
  assign overflow     = 1'b0;
`endif

  assign irqack      = (r_state == ACK);
  assign msg_valid   = (r_count != '0);
  assign msg_lineno  = msg_valid ? w_head[EW-1:CPU_W] : '0;
  assign msg_cpu     = msg_valid ? w_head[CPU_W-1:0]  : '0;
  assign count       = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_msgq.sv
// Directed self-checking bench for irq_msgq; the drop-mode case builds only with IRQ_MSGQ_DROP_EN.
module tb_irq_msgq;

  logic       clk;
  logic       rst;
  logic       notify;
  logic [7:0] lineno;
  logic [7:0] processor_id;
  logic       irqack;
  logic       msg_valid;
  logic [7:0] msg_lineno;
  logic [7:0] msg_cpu;
  logic       msg_ready;
  logic [3:0] count;
  logic       overflow;
  logic       clr_ovf;
  logic [1:0] o_dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] exp_q[$];

  irq_msgq #(.DEPTH(8), .LINE_W(8), .CPU_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .notify       (notify),
    .lineno       (lineno),
    .processor_id (processor_id),
    .irqack       (irqack),
    .msg_valid    (msg_valid),
    .msg_lineno   (msg_lineno),
    .msg_cpu      (msg_cpu),
    .msg_ready    (msg_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cpu_of(input logic [7:0] line);
    return line ^ 8'hA5;
  endfunction

  // driver: present a message, wait for its ack, release notify and return in IDLE
  task automatic send_msg(input logic [7:0] line);
    logic got;
    got          = 1'b0;
    notify       = 1'b0;
    lineno       = line;
    processor_id = cpu_of(line);
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = irqack;
    end
    check("send_ack", {31'd0, got}, 32'd1);
    notify = 1'b1;
    tick();
    tick();
    exp_q.push_back({line, cpu_of(line)});
  endtask

  // scoreboard: pop n entries and compare against the expected queue
  task automatic drain(input int n);
    logic [15:0] e;
    msg_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("drain_valid", {31'd0, msg_valid}, 32'd1);
      check("drain_line", {24'd0, msg_lineno}, {24'd0, e[15:8]});
      check("drain_cpu", {24'd0, msg_cpu}, {24'd0, e[7:0]});
      tick();
    end
    msg_ready = 1'b0;
    check("drain_empty", {31'd0, msg_valid}, 32'd0);
    check("drain_cnt", {28'd0, count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; notify = 1'b1; lineno = '0; processor_id = '0;
    msg_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ack", {31'd0, irqack}, 32'd0);
    check("rst_valid", {31'd0, msg_valid}, 32'd0);
    check("rst_line", {24'd0, msg_lineno}, 32'd0);
    check("rst_cpu", {24'd0, msg_cpu}, 32'd0);
    check("rst_cnt", {28'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);

    // single message: one-cycle ack, visible immediately after capture
    notify = 1'b0; lineno = 8'h05; processor_id = 8'h02;
    tick();
    check("one_ack", {31'd0, irqack}, 32'd1);
    check("one_valid", {31'd0, msg_valid}, 32'd1);
    check("one_line", {24'd0, msg_lineno}, 32'h05);
    check("one_cpu", {24'd0, msg_cpu}, 32'h02);
    check("one_cnt", {28'd0, count}, 32'd1);
    tick();
    check("one_ack_low", {31'd0, irqack}, 32'd0);
    check("one_wait", {30'd0, o_dbg_state}, 32'd2);
    tick();
    check("one_wait_hold", {31'd0, irqack}, 32'd0);
    check("one_no_dup", {28'd0, count}, 32'd1);
    notify = 1'b1;
    tick();
    check("one_idle", {30'd0, o_dbg_state}, 32'd0);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    check("one_pop_cnt", {28'd0, count}, 32'd0);
    check("one_pop_line", {24'd0, msg_lineno}, 32'd0);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    check("empty_ready_cnt", {28'd0, count}, 32'd0);

    // burst order: lines 0..7
    for (int i = 0; i < 8; i++) send_msg(8'(i));
    check("burst_full", {28'd0, count}, 32'd8);
    drain(8);

    // simultaneous push/pop at full
    for (int i = 0; i < 8; i++) send_msg(8'(8'h30 + i));
    void'(exp_q.pop_front());
    notify = 1'b0; lineno = 8'h40; processor_id = cpu_of(8'h40); msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    check("pp_ack", {31'd0, irqack}, 32'd1);
    check("pp_cnt", {28'd0, count}, 32'd8);
    check("pp_head", {24'd0, msg_lineno}, 32'h31);
    exp_q.push_back({8'h40, cpu_of(8'h40)});
    notify = 1'b1;
    tick();
    tick();
    drain(8);

`ifdef IRQ_MSGQ_DROP_EN
    // drop mode: full FIFO, line 12 acked but discarded
    for (int i = 0; i < 8; i++) send_msg(8'(8'h50 + i));
    notify = 1'b0; lineno = 8'd12; processor_id = cpu_of(8'd12);
    tick();
    check("drop_ack", {31'd0, irqack}, 32'd1);
    check("drop_cnt", {28'd0, count}, 32'd8);
    tick();
    check("drop_ovf", {31'd0, overflow}, 32'd1);
    notify = 1'b1;
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("drop_clr", {31'd0, overflow}, 32'd0);
    drain(8);
`else
    // backpressure: full FIFO holds off line 9 until a slot frees
    begin
      logic any_ack;
      logic got;
      for (int i = 0; i < 8; i++) send_msg(8'(8'h20 + i));
      notify = 1'b0; lineno = 8'd9; processor_id = cpu_of(8'd9);
      any_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        any_ack = any_ack | irqack;
      end
      check("bp_no_ack", {31'd0, any_ack}, 32'd0);
      check("bp_cnt", {28'd0, count}, 32'd8);
      clr_ovf = 1'b1;
      msg_ready = 1'b1;
      tick();
      msg_ready = 1'b0;
      clr_ovf = 1'b0;
      void'(exp_q.pop_front());
      got = irqack;
      if (!got) begin
        tick();
        got = irqack;
      end
      check("bp_ack", {31'd0, got}, 32'd1);
      check("bp_ovf", {31'd0, overflow}, 32'd0);
      exp_q.push_back({8'd9, cpu_of(8'd9)});
      notify = 1'b1;
      tick();
      tick();
      check("bp_cnt_after", {28'd0, count}, 32'd8);
      drain(8);
    end
`endif

    // reset during ACK with three entries
    send_msg(8'h60);
    send_msg(8'h61);
    notify = 1'b0; lineno = 8'h62; processor_id = cpu_of(8'h62);
    tick();
    check("mid_ack", {31'd0, irqack}, 32'd1);
    check("mid_cnt", {28'd0, count}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    notify = 1'b1;
    exp_q.delete();
    check("mid_rst_ack", {31'd0, irqack}, 32'd0);
    check("mid_rst_cnt", {28'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, msg_valid}, 32'd0);
    check("mid_rst_state", {30'd0, o_dbg_state}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
